tbi_rx_sync: RTL



---
 rtl/tbi_rx_sync_if.sv | 21 ++
 rtl/tbi_rx_sync.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tbi_rx_sync_if.sv
// Aligned code-group bundle between the TBI receive aligner and its neighbours.
// The master drives raw words. The slave (the aligner) returns aligned groups and status.
interface tbi_rx_sync_if;
   logic [9:0] tbi_in;
   logic [9:0] rx_cg;
   logic       rx_cg_valid;
   logic       rx_is_comma;
   logic       rx_cg_err;
   logic       sync_status;
   logic [3:0] align_offset;

   modport master (
      output tbi_in,
      input  rx_cg, rx_cg_valid, rx_is_comma, rx_cg_err, sync_status, align_offset
   );

   modport slave (
      input  tbi_in,
      output rx_cg, rx_cg_valid, rx_is_comma, rx_cg_err, sync_status, align_offset
   );
endinterface

// File: rtl/tbi_rx_sync.sv
// TBI receive aligner: finds the K28.5 comma in a 20-bit window, locks code groups
// to it, and runs the LOSS_OF_SYNC / CDET / SYNC_ACQ synchronization machine.
module tbi_rx_sync #(
   parameter int COMMAS_TO_SYNC = 3,
   parameter int ERR_LIMIT      = 4,
   parameter int GOOD_RUN       = 4
) (
   input logic          mii_clk,
   input logic          rst,
   tbi_rx_sync_if.slave rx
);

   localparam int CNT_W  = $clog2(COMMAS_TO_SYNC + 1);
   localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
   localparam int GOOD_W = $clog2(GOOD_RUN + 1);

   typedef enum logic [1:0] {LOSS_OF_SYNC, CDET, SYNC_ACQ} state_e;

   state_e            state_q, state_d;
   logic [9:0]        prev_q, prev_d;
   logic [3:0]        off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [9:0]        rx_cg_q, rx_cg_d;
   logic              rx_cg_valid_q, rx_cg_valid_d;
   logic              rx_is_comma_q, rx_is_comma_d;
   logic              rx_cg_err_q, rx_cg_err_d;
   logic              sync_q, sync_d;

   // Bit 0 is the oldest bit; tbi_in[9] never reaches a group at offsets 0..9.
   logic [18:0] win;
   logic        comma_hit;
   logic [3:0]  comma_k;
   logic [3:0]  grp_off;
   logic [9:0]  grp;
   logic [3:0]  ones;
   logic        grp_valid;
   logic        comma_elsewhere;

   function automatic logic is_comma7(input logic [6:0] b);
      return (b == 7'b1111100) || (b == 7'b0000011);
   endfunction

   assign win = {rx.tbi_in[8:0], prev_q};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      comma_hit = 1'b0;
      comma_k   = 4'd0;
      // Scanning downward leaves the lowest matching offset in comma_k.
      for (int k = 9; k >= 0; k--) begin
         if (is_comma7(win[k +: 7])) begin
            comma_hit = 1'b1;
            comma_k   = 4'(k);
         end
      end
   end

   assign grp_off = (state_q == LOSS_OF_SYNC) ? 4'd0 : off_q;
   assign grp     = win[{1'b0, grp_off} +: 10];

   always_comb begin
      ones = 4'd0;
      for (int i = 0; i < 10; i++) ones = ones + 4'(grp[i]);
   end

   assign grp_valid       = (ones >= 4'd4) && (ones <= 4'd6);
   assign comma_elsewhere = comma_hit && (comma_k != off_q);

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      good_d  = good_q;
      prev_d  = rx.tbi_in;

      unique case (state_q)
         LOSS_OF_SYNC: begin
            if (comma_hit) begin
               state_d = CDET;
               off_d   = comma_k;
               cnt_d   = CNT_W'(1);
            end
         end
         CDET: begin
            if (!grp_valid) begin
               state_d = LOSS_OF_SYNC;
               off_d   = 4'd0;
               cnt_d   = '0;
            end else if (comma_elsewhere) begin
               off_d = comma_k;
               cnt_d = CNT_W'(1);
            end else if (comma_hit) begin
               if (cnt_q == CNT_W'(COMMAS_TO_SYNC - 1)) begin
                  state_d = SYNC_ACQ;
                  cnt_d   = '0;
                  err_d   = '0;
                  good_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         SYNC_ACQ: begin
            // An error in a group always beats a pending decrement.
            if (!grp_valid || comma_elsewhere) begin
               good_d = '0;
               if (err_q == ERR_W'(ERR_LIMIT - 1)) begin
                  state_d = LOSS_OF_SYNC;
                  off_d   = 4'd0;
                  err_d   = '0;
               end else begin
                  err_d = err_q + ERR_W'(1);
               end
            end else if (err_q != '0) begin
               if (good_q == GOOD_W'(GOOD_RUN - 1)) begin
                  err_d  = err_q - ERR_W'(1);
                  good_d = '0;
               end else begin
                  good_d = good_q + GOOD_W'(1);
               end
            end else if (good_q != GOOD_W'(GOOD_RUN)) begin
               good_d = good_q + GOOD_W'(1);
            end
         end
         default: state_d = LOSS_OF_SYNC;
      endcase

      rx_cg_d       = grp;
      rx_is_comma_d = is_comma7(grp[6:0]);
      rx_cg_err_d   = !grp_valid;
      sync_d        = (state_d == SYNC_ACQ);
      rx_cg_valid_d = sync_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge mii_clk) begin
      if (rst) begin
         state_q       <= LOSS_OF_SYNC;
         prev_q        <= '0;
         off_q         <= '0;
         cnt_q         <= '0;
         err_q         <= '0;
         good_q        <= '0;
         rx_cg_q       <= '0;
         rx_cg_valid_q <= 1'b0;
         rx_is_comma_q <= 1'b0;
         rx_cg_err_q   <= 1'b0;
         sync_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         off_q         <= off_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         good_q        <= good_d;
         rx_cg_q       <= rx_cg_d;
         rx_cg_valid_q <= rx_cg_valid_d;
         rx_is_comma_q <= rx_is_comma_d;
         rx_cg_err_q   <= rx_cg_err_d;
         sync_q        <= sync_d;
      end
   end

   assign rx.rx_cg        = rx_cg_q;
   assign rx.rx_cg_valid  = rx_cg_valid_q;
   assign rx.rx_is_comma  = rx_is_comma_q;
   assign rx.rx_cg_err    = rx_cg_err_q;
   assign rx.sync_status  = sync_q;
   assign rx.align_offset = off_q;

endmodule
